// File: rtl/axis_hdr_parser.sv
// axis_hdr_parser
// Forwards an AXI4-Stream unchanged through a data FIFO while capturing the
// first 272 bits of every packet (Ethernet + IPv4 header). The decoded fields
// and an IPv4 header checksum verdict go into a metadata FIFO, and packet,
// checksum-error and runt statistics are kept.
//
// Ports
//   clk, rst                : clock, asynchronous active-high reset
//   s_tvalid/s_tready/s_tlast/s_tdata : input stream (first wire byte in MSBs)
//   m_tvalid/m_tready/m_tlast/m_tdata : output stream, beat-for-beat copy
//   meta_valid/meta_ready   : metadata handshake
//   meta_*                  : decoded header fields and flags of one packet
//   pkt_count               : packets accepted (wraps)
//   csum_err_count, runt_count : saturating error counters
module axis_hdr_parser #(
  parameter int DATA_W     = 512,
  parameter int FIFO_DEPTH = 8,
  parameter int META_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_tvalid,
  output logic              s_tready,
  input  logic              s_tlast,
  input  logic [DATA_W-1:0] s_tdata,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic              m_tlast,
  output logic [DATA_W-1:0] m_tdata,
  output logic              meta_valid,
  input  logic              meta_ready,
  output logic [47:0]       meta_dst_mac,
  output logic [47:0]       meta_src_mac,
  output logic [15:0]       meta_ethertype,
  output logic [7:0]        meta_ttl,
  output logic [7:0]        meta_proto,
  output logic [31:0]       meta_src_ip,
  output logic [31:0]       meta_dst_ip,
  output logic              meta_is_ipv4,
  output logic              meta_csum_ok,
  output logic              meta_runt,
  output logic [31:0]       pkt_count,
  output logic [15:0]       csum_err_count,
  output logic [15:0]       runt_count
);
  localparam int HDR_BITS  = 272;
  localparam int HDR_BEATS = (HDR_BITS + DATA_W - 1) / DATA_W;
  localparam int IDX_W     = (HDR_BEATS > 1) ? $clog2(HDR_BEATS) : 1;
  localparam int FA_W      = $clog2(FIFO_DEPTH);
  localparam int MA_W      = $clog2(META_DEPTH);
  localparam int META_W    = 195;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(HDR_BEATS - 1);

  typedef enum logic {ST_HDR, ST_BODY} state_t;

  // Goes high on the first edge after reset release, so intake starts synchronously.
  logic r_run;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_run <= 1'b0;
    else     r_run <= 1'b1;
  end

  // ---------------- data FIFO ----------------
  logic [DATA_W:0]   r_dmem [FIFO_DEPTH];
  logic [FA_W-1:0]   r_dwr, r_drd;
  logic [FA_W:0]     r_dcnt;
  logic              w_accept, w_dpop, w_dfull;
  logic [DATA_W:0]   w_dout;

  assign w_dfull  = (r_dcnt == (FA_W+1)'(FIFO_DEPTH));
  assign w_accept = s_tvalid && s_tready;
  assign m_tvalid = (r_dcnt != '0);
  assign w_dpop   = m_tvalid && m_tready;
  assign w_dout   = m_tvalid ? r_dmem[r_drd] : '0;
  assign m_tlast  = w_dout[DATA_W];
  assign m_tdata  = w_dout[DATA_W-1:0];

  always_ff @(posedge clk) begin
    if (w_accept) r_dmem[r_dwr] <= {s_tlast, s_tdata};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dwr  <= '0;
      r_drd  <= '0;
      r_dcnt <= '0;
    end else begin
      if (w_accept) r_dwr <= r_dwr + 1'b1;
      if (w_dpop)   r_drd <= r_drd + 1'b1;
      r_dcnt <= r_dcnt + (FA_W+1)'(w_accept) - (FA_W+1)'(w_dpop);
    end
  end

  // ---------------- parse FSM ----------------
  state_t           r_state, w_state_next;
  logic [IDX_W-1:0] r_idx;
  logic             r_pending, r_runt;
  logic             w_cap, w_hdr_done;
  logic [MA_W:0]    r_mcnt;

  // Counting the in-flight push guarantees the metadata FIFO never overflows.
  assign s_tready = r_run && !w_dfull &&
                    (({1'b0, r_mcnt} + (MA_W+2)'(r_pending)) < (MA_W+2)'(META_DEPTH));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_HDR;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_HDR:  if (w_hdr_done && !s_tlast)  w_state_next = ST_BODY;
      ST_BODY: if (w_accept && s_tlast)     w_state_next = ST_HDR;
      default: w_state_next = ST_HDR;
    endcase
  end

  always_comb begin
    w_cap      = w_accept && (r_state == ST_HDR);
    w_hdr_done = w_cap && ((r_idx == LAST_IDX) || s_tlast);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx     <= '0;
      r_pending <= 1'b0;
      r_runt    <= 1'b0;
    end else begin
      if (w_cap) r_idx <= w_hdr_done ? '0 : r_idx + 1'b1;
      r_pending <= w_hdr_done;
      if (w_hdr_done) r_runt <= (r_idx != LAST_IDX);
    end
  end

  // Each header beat lands in its own slice; beat 0 clears the later slices so
  // a runt leaves its missing header bits at zero.
  logic [HDR_BITS-1:0] w_hdr;
  for (genvar gi = 0; gi < HDR_BEATS; gi++) begin : g_slot
    localparam int HI = HDR_BITS - 1 - gi * DATA_W;
    localparam int LO = (HI - DATA_W + 1 < 0) ? 0 : HI - DATA_W + 1;
    localparam int SW = HI - LO + 1;
    logic [SW-1:0] r_slot;
    always_ff @(posedge clk or posedge rst) begin
      if (rst)                                 r_slot <= '0;
      else if (w_cap && r_idx == IDX_W'(gi))   r_slot <= s_tdata[DATA_W-1 -: SW];
      else if (w_cap && r_idx == '0)           r_slot <= '0;
    end
    assign w_hdr[HI:LO] = r_slot;
  end

  // IPv4 header checksum over bytes 14-33 (the low 160 header bits).
  logic [15:0] w_word [10];
  logic [19:0] w_sum_raw;
  logic [16:0] w_sum1;
  logic [15:0] w_sum;
  for (genvar gi = 0; gi < 10; gi++) begin : g_word
    assign w_word[gi] = w_hdr[159 - 16*gi -: 16];
  end
  always_comb begin
    w_sum_raw = '0;
    for (int k = 0; k < 10; k++) w_sum_raw = w_sum_raw + {4'b0, w_word[k]};
  end
  assign w_sum1 = {1'b0, w_sum_raw[15:0]} + {13'b0, w_sum_raw[19:16]};
  assign w_sum  = w_sum1[15:0] + {15'b0, w_sum1[16]};

  logic w_is_ipv4, w_csum_ok;
  logic [META_W-1:0] w_meta_in;
  assign w_is_ipv4 = (w_hdr[175:160] == 16'h0800) && !r_runt;
  assign w_csum_ok = (w_sum == 16'hFFFF);
  assign w_meta_in = {w_hdr[271:224], w_hdr[223:176], w_hdr[175:160], w_hdr[95:88],
                      w_hdr[87:80], w_hdr[63:32], w_hdr[31:0], w_is_ipv4, w_csum_ok, r_runt};

  // ---------------- metadata FIFO ----------------
  logic [META_W-1:0] r_mmem [META_DEPTH];
  logic [MA_W-1:0]   r_mwr, r_mrd;
  logic              w_mpop;
  logic [META_W-1:0] w_mout;

  assign meta_valid = (r_mcnt != '0);
  assign w_mpop     = meta_valid && meta_ready;
  assign w_mout     = meta_valid ? r_mmem[r_mrd] : '0;
  assign {meta_dst_mac, meta_src_mac, meta_ethertype, meta_ttl, meta_proto,
          meta_src_ip, meta_dst_ip, meta_is_ipv4, meta_csum_ok, meta_runt} = w_mout;

  always_ff @(posedge clk) begin
    if (r_pending) r_mmem[r_mwr] <= w_meta_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mwr  <= '0;
      r_mrd  <= '0;
      r_mcnt <= '0;
    end else begin
      if (r_pending) r_mwr <= r_mwr + 1'b1;
      if (w_mpop)    r_mrd <= r_mrd + 1'b1;
      r_mcnt <= r_mcnt + (MA_W+1)'(r_pending) - (MA_W+1)'(w_mpop);
    end
  end

  // ---------------- statistics ----------------
  logic [31:0] r_pkt;
  logic [15:0] r_cerr, r_runtc;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pkt   <= '0;
      r_cerr  <= '0;
      r_runtc <= '0;
    end else begin
      if (w_accept && s_tlast) r_pkt <= r_pkt + 1'b1;
      if (r_pending && w_is_ipv4 && !w_csum_ok && r_cerr != 16'hFFFF) r_cerr <= r_cerr + 1'b1;
      if (r_pending && r_runt && r_runtc != 16'hFFFF) r_runtc <= r_runtc + 1'b1;
    end
  end
  assign pkt_count      = r_pkt;
  assign csum_err_count = r_cerr;
  assign runt_count     = r_runtc;

endmodule

// File: doc/axis_hdr_parser.md
# axis_hdr_parser

Parametrised AXI4-Stream Ethernet/IPv4 header parser for the packet datapath. It forwards every beat unchanged through a data FIFO. In parallel it captures the first 272 bits of each packet (14-byte Ethernet plus 20-byte IPv4 header), which may span several beats. It then pushes the decoded fields, with an IPv4 checksum verdict, into a metadata FIFO, and keeps per-block packet statistics.

## Interface
- DATA_W, 512: TDATA width in bits; a multiple of 32 and at least 64. HDR_BEATS = ceil(272/DATA_W).
- FIFO_DEPTH, 8: data FIFO depth in beats; a power of 2 and at least 2.
- META_DEPTH, 4: metadata FIFO depth in entries; a power of 2 and at least 2.
- clk  in  1  clock. One clock domain only.
- rst  in  1  asynchronous, active-high reset.
- s_tvalid / s_tready / s_tlast  in/out/in  1  input stream handshake.
- s_tdata  in  DATA_W  input data. The first byte on the wire is in TDATA[DATA_W-1:DATA_W-8].
- m_tvalid / m_tready / m_tlast  out/in/out  1  output stream handshake.
- m_tdata  out  DATA_W  output data.
- meta_valid / meta_ready  out/in  1  metadata handshake.
- meta_dst_mac, meta_src_mac  out  48  packet bytes 0-5 and 6-11.
- meta_ethertype  out  16  bytes 12-13.
- meta_ttl, meta_proto  out  8  bytes 22 and 23.
- meta_src_ip, meta_dst_ip  out  32  bytes 26-29 and 30-33.
- meta_is_ipv4  out  1  ethertype == 16'h0800, and not a runt.
- meta_csum_ok  out  1  IPv4 header checksum (bytes 14-33) verifies.
- meta_runt  out  1  packet ended before 272 bits were received.
- pkt_count  out  32  packets accepted; wraps.
- csum_err_count, runt_count  out  16  counts of IPv4 packets with a bad checksum and of runts; both saturate at 16'hFFFF.

## Operation
- A beat is accepted when s_tvalid && s_tready.
- s_tready = !data_full && (meta_count + pending < META_DEPTH). With this rule a pending metadata push always has room.
- Parse FSM has two states:
  - HDR: accepted beats shift into a 272-bit header register, MSB-first. beat_idx counts from 0. The header is complete when beat_idx == HDR_BEATS-1 or s_tlast is set.
    - On completion, set pending. If s_tlast is clear, go to BODY; otherwise stay in HDR with beat_idx = 0.
    - On a runt, missing header bits are zero.
  - BODY: beats pass through without capture. An accepted s_tlast returns the FSM to HDR with beat_idx = 0.
- Pending cycle: push one metadata entry and clear pending.
  - The checksum is the ones-complement sum of the ten 16-bit words in bytes 14-33, with end-around carry folded twice. csum_ok = (sum == 16'hFFFF).
  - csum_err_count increments when is_ipv4 && !csum_ok.
  - runt_count increments when meta_runt is set.
- pkt_count increments on every accepted s_tlast.
- Data FIFO stores {tlast, tdata}. Ordering and content are preserved exactly.
- Simultaneous push and pop on a full data FIFO: the push is impossible, because s_tready is low when the FIFO is full.
- Simultaneous push and pop on an empty or full FIFO otherwise: count is unchanged, and the pointers wrap modulo depth.
- Metadata FIFO pops on meta_valid && meta_ready. It is independent of the data-path pops.
- meta_is_ipv4 is forced to 0 for runts. csum_ok is reported but not counted for runts.

## Timing
- Reset values:
  - s_tready = 0 while rst is high, then 1 after release.
  - m_tvalid = 0, m_tlast = 0, m_tdata = 0.
  - meta_valid = 0; all meta_* fields = 0.
  - All counters = 0; FSM = HDR; pending = 0; both FIFOs empty.
- Data latency: a beat accepted at edge N is on m_* after edge N; m_tvalid is high in cycle N+1.
- Metadata latency: the header-completing beat accepted at edge N is pushed at edge N+1; meta_valid is high from cycle N+2.
- Counters update at the same edge as the event they count.
- Reset asserted mid-packet discards all partial state and FIFO contents immediately. Asynchronous assertion takes effect without waiting for an edge; release is synchronised to clk.
- m_tvalid, once high, does not drop until the beat is taken. The same holds for meta_valid.

## Test plan
- DATA_W=512, 3-beat packet: dst C20068B30001, src C20168B30001, ethertype 86DD, IPv4 4500 0030 … TTL 01, proto 11, csum 1835, src C0A8001E, dst E0000002.
  - Required: 3 identical output beats with TLAST on beat 2; meta fields as given; is_ipv4=0, csum_ok=0, runt=0; pkt_count=1; csum_err_count=0.
- Same packet with ethertype 0800: csum 18F5 gives is_ipv4=1, csum_ok=1; csum 1835 gives csum_ok=0 and csum_err_count=1.
- DATA_W=64, 24-beat packet with the same header: HDR_BEATS=5; meta_valid first high 2 cycles after beat 4 is accepted; fields as in scenario 1; 24 beats forwarded.
- DATA_W=64, single-beat packet with s_tlast: meta_runt=1, is_ipv4=0, src_ip=0; runt_count=1; the beat is forwarded with TLAST=1.
- Backpressure, with m_tready=0 and meta_ready=0, streaming 1-beat packets at DATA_W=512:
  - s_tready falls after exactly 4 packets (metadata limit).
  - Raising meta_ready alone lets intake continue until 8 beats are held (data limit).
  - Releasing both drains everything in order with no loss or duplication.
- Assert rst during beat 1 of a 3-beat packet, then send a clean packet: all outputs read zero during reset; afterwards exactly one correct meta entry and pkt_count=1.
